// File: rtl/pwm_measure.sv
`default_nettype none
// ============================================================================
// Module   : pwm_measure
// Brief    : Measures the high time and the low time of a digital input, in
//            clkin cycles. Results come out in the same onperiod/offperiod
//            form that the pwm generator takes. A one-cycle valid strobe
//            follows every complete high+low period.
// Options  : PWM_MEASURE_SYNC_EN - when defined, a two-flop synchroniser
//            sits in front of the sample register, for asynchronous pin
//            inputs. This adds two cycles of latency. The counts do not
//            change.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_measure #(
    parameter int WIDTH = 17
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sigin,
    output logic [WIDTH-1:0] onperiod,
    output logic [WIDTH-1:0] offperiod,
    output logic             valid,
    output logic             ovf
);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_HIGH = 2'd1;
    localparam logic [1:0]       c_LOW  = 2'd2;
    localparam logic [WIDTH-1:0] c_MAX  = '1;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_sig_in;
    logic             r_s;
    logic             r_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_max;
    logic [WIDTH-1:0] w_cnt_inc;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_cnt;
    logic             r_hi_sat;
    logic [WIDTH-1:0] r_onperiod;
    logic [WIDTH-1:0] r_offperiod;
    logic             r_valid;
    logic             r_ovf;

`ifdef PWM_MEASURE_SYNC_EN
    logic r_meta;
    logic r_sync;

    // Two-flop synchroniser for sigin that is asynchronous to clkin.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= sigin;
            r_sync <= r_meta;
        end
    end

    assign w_sig_in = r_sync;
`else
    assign w_sig_in = sigin;
`endif

    // Sample register s and its one-cycle-delayed copy q, for edge detection.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_s <= 1'b0;
            r_q <= 1'b0;
        end else begin
            r_s <= w_sig_in;
            r_q <= r_s;
        end
    end

    assign w_rise    = r_s & ~r_q;
    assign w_fall    = ~r_s & r_q;
    // The phase counter holds at all-ones so that a long phase reads back as
    // saturated and never as a small wrapped value.
    assign w_cnt_max = (r_cnt == c_MAX);
    assign w_cnt_inc = w_cnt_max ? r_cnt : (r_cnt + c_ONE);

    // Measurement FSM. A rising edge starts the high phase. A falling edge
    // latches the high count. The next rising edge publishes the pair.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_hi_cnt    <= '0;
            r_hi_sat    <= 1'b0;
            r_onperiod  <= '0;
            r_offperiod <= '0;
            r_valid     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en) begin
                // Abort the measurement. The published results stay.
                r_state <= c_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        // A level or partial phase has no defined start,
                        // so only a real rising edge begins a measurement.
                        if (w_rise) begin
                            r_state <= c_HIGH;
                            r_cnt   <= c_ONE;
                        end
                    end
                    c_HIGH: begin
                        if (w_fall) begin
                            r_hi_cnt <= r_cnt;
                            r_hi_sat <= w_cnt_max;
                            r_cnt    <= c_ONE;
                            r_state  <= c_LOW;
                        end else if (r_s) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    c_LOW: begin
                        if (w_rise) begin
                            r_onperiod  <= r_hi_cnt;
                            r_offperiod <= r_cnt;
                            r_valid     <= 1'b1;
                            r_ovf       <= r_hi_sat | w_cnt_max;
                            r_cnt       <= c_ONE;
                            r_state     <= c_HIGH;
                        end else if (!r_s) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign onperiod  = r_onperiod;
    assign offperiod = r_offperiod;
    assign valid     = r_valid;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pwm_measure.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_measure
// Brief    : Directed self-checking bench for pwm_measure. One instance uses
//            the default WIDTH and a second instance uses WIDTH=4. Both see
//            the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_measure;

`ifdef PWM_MEASURE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clkin = 1'b0;
    logic        rst;
    logic        en;
    logic        sigin;
    logic [16:0] onperiod;
    logic [16:0] offperiod;
    logic        valid;
    logic        ovf;
    logic [3:0]  on4;
    logic [3:0]  off4;
    logic        valid4;
    logic        ovf4;

    pwm_measure #(.WIDTH(17)) dut (
        .clkin    (clkin),
        .rst      (rst),
        .en       (en),
        .sigin    (sigin),
        .onperiod (onperiod),
        .offperiod(offperiod),
        .valid    (valid),
        .ovf      (ovf)
    );

    pwm_measure #(.WIDTH(4)) dut4 (
        .clkin    (clkin),
        .rst      (rst),
        .en       (en),
        .sigin    (sigin),
        .onperiod (on4),
        .offperiod(off4),
        .valid    (valid4),
        .ovf      (ovf4)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] on;
        logic [16:0] off;
        logic        ovf;
        int          c;
    } rec_t;

    rec_t q17[$];
    rec_t q4[$];
    rec_t r17;
    rec_t r4;

    // Log every valid pulse with its results and its cycle number.
    always @(negedge clkin) begin
        if (valid) begin
            r17.on  = onperiod;
            r17.off = offperiod;
            r17.ovf = ovf;
            r17.c   = cyc;
            q17.push_back(r17);
        end
        if (valid4) begin
            r4.on  = {13'd0, on4};
            r4.off = {13'd0, off4};
            r4.ovf = ovf4;
            r4.c   = cyc;
            q4.push_back(r4);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        sigin = v;
        step(n);
    endtask

    // Abort any measurement in progress and clear the logs.
    task automatic go_idle();
        sigin = 1'b0;
        step(LAT + 2);
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(1);
        q17.delete();
        q4.delete();
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        sigin = 1'b0;
        step(2);
        check("reset_onperiod",  onperiod,  0);
        check("reset_offperiod", offperiod, 0);
        check("reset_valid",     valid,     0);
        check("reset_ovf",       ovf,       0);
        rst = 1'b0;

        // Test 1: sigin is high 2 cycles and low 1 cycle, repeating.
        go_idle();
        t0 = cyc;
        repeat (6) begin
            drive(1'b1, 2);
            drive(1'b0, 1);
        end
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t1_count", q17.size(), 6);
        if (q17.size() > 0) check("t1_latency", q17[0].c - t0, 4 + LAT);
        for (int i = 0; i < q17.size(); i++) begin
            check("t1_on",  q17[i].on,  2);
            check("t1_off", q17[i].off, 1);
            check("t1_ovf", q17[i].ovf, 0);
            if (i > 0) check("t1_spacing", q17[i].c - q17[i-1].c, 3);
        end

        // Test 2: pwm-like source with on=7 and off=1.
        go_idle();
        repeat (5) begin
            drive(1'b1, 7);
            drive(1'b0, 1);
        end
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t2_count", q17.size(), 5);
        for (int i = 0; i < q17.size(); i++) begin
            check("t2_on",  q17[i].on,  7);
            check("t2_off", q17[i].off, 1);
            if (i > 0) check("t2_spacing", q17[i].c - q17[i-1].c, 8);
        end

        // Test 3: the WIDTH=4 instance saturates during a 20-cycle high phase.
        go_idle();
        drive(1'b1, 20);
        drive(1'b0, 3);
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t3_count4", q4.size(), 2);
        if (q4.size() == 2) begin
            check("t3_sat_on",   q4[0].on,  15);
            check("t3_sat_off",  q4[0].off, 3);
            check("t3_sat_ovf",  q4[0].ovf, 1);
            check("t3_next_on",  q4[1].on,  2);
            check("t3_next_off", q4[1].off, 2);
            check("t3_next_ovf", q4[1].ovf, 0);
        end
        check("t3_count17", q17.size(), 2);
        if (q17.size() > 0) begin
            check("t3_w17_on",  q17[0].on,  20);
            check("t3_w17_ovf", q17[0].ovf, 0);
        end
        check("t3_ovf4_held", ovf4, 0);

        // Test 4: en drops for 5 cycles in the middle of a high phase.
        go_idle();
        drive(1'b1, 3);
        en = 1'b0;
        drive(1'b1, 5);
        check("t4_no_valid",  q17.size(), 0);
        check("t4_hold_on",   onperiod,   2);
        check("t4_hold_off",  offperiod,  2);
        check("t4_valid_low", valid,      0);
        en = 1'b1;
        drive(1'b1, 2);
        drive(1'b0, 2);
        t0 = cyc;
        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t4_count", q17.size(), 1);
        if (q17.size() > 0) begin
            check("t4_on",      q17[0].on,      3);
            check("t4_off",     q17[0].off,     2);
            check("t4_latency", q17[0].c - t0,  6 + LAT);
        end

        // Test 5: a reset pulse arrives in the middle of a low phase.
        go_idle();
        drive(1'b1, 4);
        drive(1'b0, LAT + 3);
        check("t5_pre_on", onperiod, 3);
        rst = 1'b1;
        #1;
        check("t5_rst_on",    onperiod,  0);
        check("t5_rst_off",   offperiod, 0);
        check("t5_rst_valid", valid,     0);
        check("t5_rst_ovf",   ovf,       0);
        step(2);
        rst = 1'b0;
        q17.delete();
        q4.delete();
        drive(1'b0, 2);
        t0 = cyc;
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t5_count", q17.size(), 1);
        if (q17.size() > 0) begin
            check("t5_on",      q17[0].on,     2);
            check("t5_off",     q17[0].off,    3);
            check("t5_latency", q17[0].c - t0, 6 + LAT);
        end

        // Test 6: sigin toggles every cycle.
        go_idle();
        t0 = cyc;
        repeat (8) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b1, 1);
        drive(1'b0, LAT + 4);
        check("t6_count", q17.size(), 8);
        if (q17.size() > 0) check("t6_latency", q17[0].c - t0, 3 + LAT);
        for (int i = 0; i < q17.size(); i++) begin
            check("t6_on",  q17[i].on,  1);
            check("t6_off", q17[i].off, 1);
            if (i > 0) check("t6_spacing", q17[i].c - q17[i-1].c, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
